// File: rtl/multicycle_seq.sv
// multicycle_seq: control sequencer for a multi-cycle processor.
// Walks FETCH -> DECODE -> EXEC -> (MEM) -> (WB) for each instruction.
// Every control output is decoded combinationally from the current state
// and the latched opcode/function fields.
// A memory handshake (FETCH or MEM) that waits too long sends the FSM to
// HALT and sets a sticky fault flag.
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   op, func                      instruction fields, latched when ir_en=1
//   imem_ready, dmem_ready        memory acknowledges
//   branch_taken                  branch comparator result (used in EXEC)
//   imem_req, ir_en               fetch request, instruction register load
//   dmem_req, mem_wr              data memory request, write qualifier
//   reg_wr, pc_en, pc_sel         register write, PC update, PC source
//   wb_sel                        writeback source select
//   alu_op, alu_s1, alu_s2, flag  ALU controls
//   state                         current FSM state encoding
//   fault                         sticky handshake-timeout indicator
module multicycle_seq #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] op,
    input  logic [2:0] func,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    input  logic       branch_taken,
    output logic       imem_req,
    output logic       ir_en,
    output logic       dmem_req,
    output logic       mem_wr,
    output logic       reg_wr,
    output logic       pc_en,
    output logic [1:0] pc_sel,
    output logic [1:0] wb_sel,
    output logic [2:0] alu_op,
    output logic       alu_s1,
    output logic       alu_s2,
    output logic       flag,
    output logic [2:0] state,
    output logic       fault
);

    localparam int unsigned CW = (WAIT_MAX < 1) ? 1 : $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        S_FETCH  = 3'b000,
        S_DECODE = 3'b001,
        S_EXEC   = 3'b010,
        S_MEM    = 3'b011,
        S_WB     = 3'b100,
        S_HALT   = 3'b101
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [2:0]    r_op;
    logic [2:0]    r_func;
    logic [CW-1:0] r_wait;
    logic [CW-1:0] w_wait_next;
    logic          r_fault;
    logic          w_timeout;
    logic          w_wait_hit;
    logic          w_jump_ok;

    assign state      = r_state;
    assign fault      = r_fault;
    assign w_wait_hit = (r_wait == CW'(WAIT_MAX));
    assign w_jump_ok  = (r_func == 3'b000) || (r_func == 3'b100);

    always_comb begin
        imem_req    = 1'b0;
        ir_en       = 1'b0;
        dmem_req    = 1'b0;
        mem_wr      = 1'b0;
        reg_wr      = 1'b0;
        pc_en       = 1'b0;
        pc_sel      = 2'b00;
        wb_sel      = 2'b00;
        alu_op      = 3'b000;
        alu_s1      = 1'b0;
        alu_s2      = 1'b0;
        flag        = 1'b0;
        w_next      = r_state;
        w_wait_next = '0;
        w_timeout   = 1'b0;

        case (r_state)
            S_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_en  = 1'b1;
                    w_next = S_DECODE;
                // WAIT_MAX low cycles are tolerated; one more is a fault,
                // and a ready in that cycle still wins
                end else if (w_wait_hit) begin
                    w_timeout = 1'b1;
                    w_next    = S_HALT;
                end else begin
                    w_wait_next = r_wait + 1'b1;
                end
            end

            S_DECODE: begin
                w_next = (r_op == 3'b111) ? S_HALT : S_EXEC;
            end

            S_EXEC: begin
                case (r_op)
                    3'b000, 3'b001: begin
                        alu_s2 = (r_op == 3'b000);
                        case (r_func)
                            3'b000: begin alu_op = 3'b000; flag = 1'b0; end
                            3'b001: begin alu_op = 3'b000; flag = 1'b1; end
                            3'b010: begin alu_op = 3'b001; flag = 1'b0; end
                            3'b011: begin alu_op = 3'b001; flag = 1'b1; end
                            3'b100: begin alu_op = 3'b010; flag = 1'b0; end
                            3'b101: begin alu_op = 3'b011; flag = 1'b0; end
                            3'b110: begin alu_op = 3'b011; flag = 1'b1; end
                            default: begin alu_op = 3'b100; flag = 1'b0; end
                        endcase
                        w_next = S_WB;
                    end
                    3'b010, 3'b011: w_next = S_MEM;
                    3'b100: begin
                        alu_s1 = 1'b1;
                        pc_en  = 1'b1;
                        pc_sel = branch_taken ? 2'b01 : 2'b00;
                        w_next = S_FETCH;
                    end
                    3'b101: begin
                        alu_s1 = 1'b1;
                        w_next = S_WB;
                    end
                    3'b110:  w_next = S_WB;
                    default: w_next = S_FETCH;
                endcase
            end

            S_MEM: begin
                dmem_req = 1'b1;
                mem_wr   = (r_op == 3'b011);
                if (dmem_ready) begin
                    if (r_op == 3'b011) begin
                        pc_en  = 1'b1;
                        w_next = S_FETCH;
                    end else begin
                        w_next = S_WB;
                    end
                end else if (w_wait_hit) begin
                    w_timeout = 1'b1;
                    w_next    = S_HALT;
                end else begin
                    w_wait_next = r_wait + 1'b1;
                end
            end

            S_WB: begin
                reg_wr = 1'b1;
                pc_en  = 1'b1;
                case (r_op)
                    3'b010:  wb_sel = 2'b01;
                    3'b101: begin
                        wb_sel = 2'b10;
                        // unsupported jump variants retire as a NOP
                        if (w_jump_ok) pc_sel = 2'b10;
                        else           reg_wr = 1'b0;
                    end
                    3'b110:  wb_sel = 2'b11;
                    default: wb_sel = 2'b00;
                endcase
                w_next = S_FETCH;
            end

            S_HALT:  w_next = S_HALT;
            default: w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_op    <= '0;
            r_func  <= '0;
            r_wait  <= '0;
            r_fault <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wait  <= w_wait_next;
            if (w_timeout) r_fault <= 1'b1;
            if (ir_en) begin
                r_op   <= op;
                r_func <= func;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_seq.sv
// Bench for multicycle_seq. For each instruction a reference model derives,
// from the opcode, function, memory delays and branch outcome, the expected
// per-cycle sequence of states and control outputs, which is compared
// cycle by cycle against the DUT.
module tb_multicycle_seq;

    localparam int WM = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] op, func;
    logic       imem_ready, dmem_ready, branch_taken;
    logic       imem_req, ir_en, dmem_req, mem_wr, reg_wr, pc_en;
    logic [1:0] pc_sel, wb_sel;
    logic [2:0] alu_op;
    logic       alu_s1, alu_s2, flag;
    logic [2:0] state;
    logic       fault;
    logic [19:0] obs;

    int   checks = 0;
    int   failures = 0;
    logic exp_fault = 1'b0;

    multicycle_seq #(.WAIT_MAX(WM)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .func(func),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .branch_taken(branch_taken),
        .imem_req(imem_req), .ir_en(ir_en), .dmem_req(dmem_req),
        .mem_wr(mem_wr), .reg_wr(reg_wr), .pc_en(pc_en),
        .pc_sel(pc_sel), .wb_sel(wb_sel), .alu_op(alu_op),
        .alu_s1(alu_s1), .alu_s2(alu_s2), .flag(flag),
        .state(state), .fault(fault)
    );

    always #5 clk = ~clk;

    assign obs = {state, imem_req, ir_en, dmem_req, mem_wr, reg_wr, pc_en,
                  pc_sel, wb_sel, alu_op, alu_s1, alu_s2, flag, fault};

    // Output vector layout: state,imem_req,ir_en,dmem_req,mem_wr,reg_wr,
    // pc_en,pc_sel,wb_sel,alu_op,alu_s1,alu_s2,flag,fault
    function automatic logic [19:0] vec(
        input logic [2:0] st, input logic imr, input logic ir,
        input logic dr, input logic mw, input logic rw, input logic pe,
        input logic [1:0] ps, input logic [1:0] ws, input logic [2:0] ao,
        input logic s1, input logic s2, input logic fl, input logic ft);
        return {st, imr, ir, dr, mw, rw, pe, ps, ws, ao, s1, s2, fl, ft};
    endfunction

    function automatic logic [19:0] idle_vec(input logic [2:0] st, input logic ft);
        return vec(st, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0,
                   3'd0, 1'b0, 1'b0, 1'b0, ft);
    endfunction

    task automatic chk(input string tag, input logic [19:0] got, input logic [19:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %05h expected %05h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Inputs are already driven; check mid-cycle, then advance past the edge.
    task automatic cyc(input string tag, input logic [19:0] exp);
        @(negedge clk);
        chk(tag, obs, exp);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
        #1;
        exp_fault = 1'b0;
        chk("reset", obs, vec(3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                              2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Runs one instruction from FETCH; halted=1 if the DUT ends in HALT.
    task automatic run_instr(input logic [2:0] iop, input logic [2:0] ifn,
                             input int idly, input int ddly, input logic bt,
                             output logic halted);
        logic [2:0] ao;
        logic       fl, s1, s2, pe, st, jok, rw;
        logic [1:0] ps, ws;
        halted = 1'b0;

        for (int k = 0; k <= WM; k++) begin
            imem_ready   = (k == idly);
            op           = imem_ready ? iop : 3'($urandom);
            func         = imem_ready ? ifn : 3'($urandom);
            branch_taken = 1'($urandom);
            cyc("fetch", vec(3'd0, 1'b1, imem_ready, 1'b0, 1'b0, 1'b0, 1'b0,
                             2'd0, 2'd0, 3'd0, 1'b0, 1'b0, 1'b0, exp_fault));
            if (imem_ready) break;
            if (k == WM) begin
                exp_fault = 1'b1;
                halted = 1'b1;
            end
        end
        imem_ready = 1'b0;
        op   = 3'($urandom);
        func = 3'($urandom);
        if (halted) begin
            cyc("fetch_timeout", idle_vec(3'd5, exp_fault));
            return;
        end

        cyc("decode", idle_vec(3'd1, exp_fault));
        if (iop == 3'd7) begin
            halted = 1'b1;
            cyc("halt_op", idle_vec(3'd5, exp_fault));
            return;
        end

        // ALU table indexed by function: add sub nand nor sltu sll srl sra
        ao = 3'd0; fl = 1'b0;
        if (iop <= 3'd1) begin
            case (ifn)
                3'd0: begin ao = 3'd0; fl = 1'b0; end
                3'd1: begin ao = 3'd0; fl = 1'b1; end
                3'd2: begin ao = 3'd1; fl = 1'b0; end
                3'd3: begin ao = 3'd1; fl = 1'b1; end
                3'd4: begin ao = 3'd2; fl = 1'b0; end
                3'd5: begin ao = 3'd3; fl = 1'b0; end
                3'd6: begin ao = 3'd3; fl = 1'b1; end
                default: begin ao = 3'd4; fl = 1'b0; end
            endcase
        end
        s1 = (iop == 3'd4) || (iop == 3'd5);
        s2 = (iop == 3'd0);
        pe = (iop == 3'd4);
        ps = (iop == 3'd4 && bt) ? 2'd1 : 2'd0;
        branch_taken = bt;
        cyc("exec", vec(3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, pe, ps, 2'd0,
                        ao, s1, s2, fl, exp_fault));
        branch_taken = 1'($urandom);
        if (iop == 3'd4) return;

        if (iop == 3'd2 || iop == 3'd3) begin
            st = (iop == 3'd3);
            for (int k = 0; k <= WM; k++) begin
                dmem_ready = (k == ddly);
                cyc("mem", vec(3'd3, 1'b0, 1'b0, 1'b1, st, 1'b0,
                               dmem_ready && st, 2'd0, 2'd0, 3'd0,
                               1'b0, 1'b0, 1'b0, exp_fault));
                if (dmem_ready) break;
                if (k == WM) begin
                    exp_fault = 1'b1;
                    halted = 1'b1;
                end
            end
            dmem_ready = 1'b0;
            if (halted) begin
                cyc("mem_timeout", idle_vec(3'd5, exp_fault));
                return;
            end
            if (st) return;
        end

        jok = (iop == 3'd5) && (ifn == 3'd0 || ifn == 3'd4);
        rw  = !((iop == 3'd5) && !jok);
        ps  = jok ? 2'd2 : 2'd0;
        ws  = (iop == 3'd2) ? 2'd1 : (iop == 3'd5) ? 2'd2 :
              (iop == 3'd6) ? 2'd3 : 2'd0;
        cyc("wb", vec(3'd4, 1'b0, 1'b0, 1'b0, 1'b0, rw, 1'b1, ps, ws,
                      3'd0, 1'b0, 1'b0, 1'b0, exp_fault));
    endtask

    task automatic halt_hold(input int n);
        for (int i = 0; i < n; i++) begin
            imem_ready = 1'(i % 2);
            dmem_ready = 1'($urandom);
            cyc("halt_hold", idle_vec(3'd5, exp_fault));
        end
        imem_ready = 1'b0;
        dmem_ready = 1'b0;
    endtask

    initial begin
        logic h;
        int   id, dd;
        op = '0; func = '0;
        imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
        @(posedge clk);
        #1;
        do_reset();

        // directed cases
        run_instr(3'd0, 3'd0, 0, 0, 1'b0, h);   // ADD
        run_instr(3'd2, 3'd5, 0, 3, 1'b0, h);   // load, 3 wait cycles
        run_instr(3'd4, 3'd0, 0, 0, 1'b1, h);   // branch taken
        run_instr(3'd4, 3'd0, 0, 0, 1'b0, h);   // branch not taken
        run_instr(3'd3, 3'd2, 1, 2, 1'b0, h);   // store
        run_instr(3'd5, 3'd0, 0, 0, 1'b0, h);   // jump
        run_instr(3'd5, 3'd4, 0, 0, 1'b0, h);   // jump variant
        run_instr(3'd5, 3'd3, 0, 0, 1'b0, h);   // jump NOP
        run_instr(3'd6, 3'd1, 0, 0, 1'b0, h);   // U-type
        run_instr(3'd1, 3'd7, 2, 0, 1'b0, h);   // I-type sra
        run_instr(3'd0, 3'd1, WM, 0, 1'b0, h);  // fetch ready at the limit
        run_instr(3'd2, 3'd0, 0, WM, 1'b0, h);  // mem ready at the limit

        // randomized instruction stream
        for (int n = 0; n < 80; n++) begin
            id = ($urandom_range(0, 7) == 0) ? WM : int'($urandom_range(0, 3));
            dd = ($urandom_range(0, 7) == 0) ? WM : int'($urandom_range(0, 3));
            run_instr(3'($urandom_range(0, 6)), 3'($urandom), id, dd,
                      1'($urandom), h);
        end

        // reset in the middle of a store's MEM wait
        imem_ready = 1'b1; op = 3'd3; func = 3'd0;
        cyc("fetch", vec(3'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0,
                         3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        imem_ready = 1'b0;
        cyc("decode", idle_vec(3'd1, 1'b0));
        cyc("exec", idle_vec(3'd2, 1'b0));
        cyc("mem", vec(3'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 2'd0,
                       3'd0, 1'b0, 1'b0, 1'b0, 1'b0));
        #1;
        do_reset();
        run_instr(3'd0, 3'd2, 0, 0, 1'b0, h);

        // fetch timeout then held in HALT
        run_instr(3'd0, 3'd0, 1000, 0, 1'b0, h);
        halt_hold(4);
        do_reset();

        // mem timeout
        run_instr(3'd3, 3'd0, 0, 1000, 1'b0, h);
        halt_hold(2);
        do_reset();

        // halt opcode ignores further fetch acknowledges
        run_instr(3'd7, 3'd0, 0, 0, 1'b0, h);
        halt_hold(4);
        do_reset();
        run_instr(3'd0, 3'd0, 0, 0, 1'b0, h);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/multicycle_seq.md
MULTICYCLE_SEQ -- requirements
Module: multicycle_seq

Interface
REQ-001 Parameter: WAIT_MAX, default 15, maximum number of wait cycles tolerated on any memory handshake before a fault.
REQ-002 Port: clk  in  1  single clock; all state updates on rising edge.
REQ-003 Port: rst_n  in  1  asynchronous, active-low reset.
REQ-004 Port: op  in  3  opcode field of the instruction bus; sampled only when ir_en is high.
REQ-005 Port: func  in  3  function field of the instruction bus; sampled only when ir_en is high.
REQ-006 Port: imem_ready  in  1  instruction memory acknowledge for imem_req.
REQ-007 Port: dmem_ready  in  1  data memory acknowledge for dmem_req.
REQ-008 Port: branch_taken  in  1  branch comparator result; valid in EXEC.
REQ-009 Port: imem_req  out  1  instruction fetch request.
REQ-010 Port: ir_en  out  1  instruction register load enable.
REQ-011 Port: dmem_req  out  1  data memory request.
REQ-012 Port: mem_wr  out  1  data memory write qualifier.
REQ-013 Port: reg_wr  out  1  register file write enable.
REQ-014 Port: pc_en  out  1  PC update enable.
REQ-015 Port: pc_sel  out  2  next-PC source: 00 PC+2, 01 branch target, 10 ALU result.
REQ-016 Port: wb_sel  out  2  writeback source: 00 ALU, 01 memory data, 10 PC+2, 11 immediate.
REQ-017 Port: alu_op  out  3  ALU operation; alu_s1, alu_s2  out  1 each: ALU operand selects; flag  out  1: ALU variant bit.
REQ-018 Port: state  out  3  current state: FETCH 000, DECODE 001, EXEC 010, MEM 011, WB 100, HALT 101.
REQ-019 Port: fault  out  1  sticky handshake-timeout indicator.

Function
REQ-020 op/func are latched into internal op_q/func_q in the cycle ir_en is high; every later decode uses op_q/func_q only.
REQ-021 FETCH: imem_req=1; on imem_ready, ir_en=1 for that cycle and the FSM moves to DECODE; otherwise the FSM stays in FETCH.
REQ-022 DECODE: lasts exactly one cycle; op_q=111 -> HALT, else -> EXEC.
REQ-023 EXEC: drives alu_op/flag/alu_s1/alu_s2 from op_q/func_q: R-type (000) add 000/0, sub 000/1, nand 001/0, nor 001/1, sltu 010, sll 011/0, srl 011/1, sra 100, with alu_s2=1; I-type (001) uses the same mapping with alu_s2=0; load/store/branch/jump use alu_op=000; branch/JAL use alu_s1=1.
REQ-024 EXEC transitions: op_q 010 or 011 -> MEM; op_q 100 -> FETCH, with pc_en=1 and pc_sel=01 if branch_taken else 00; op_q 000/001/101/110 -> WB.
REQ-025 MEM: dmem_req=1, mem_wr=(op_q==011); on dmem_ready, a load -> WB and a store -> FETCH with pc_en=1, pc_sel=00; otherwise the FSM stays in MEM.
REQ-026 WB: reg_wr=1, pc_en=1, then -> FETCH; wb_sel is 00 for R/I, 01 for load, 10 for jump, 11 for U-type (110).
REQ-027 WB pc_sel: jump (101) with func_q 000 or 100 uses 10; all other opcodes use 00.
REQ-028 Jump with func_q other than 000/100: WB with reg_wr=0, pc_sel=00 (treated as a NOP).
REQ-029 All outputs not explicitly asserted in a state are 0.
REQ-030 Outputs are decoded combinationally from state and op_q/func_q; branch_taken, imem_ready and dmem_ready affect outputs in the same cycle.
REQ-031 Latency with zero-wait memory: R/I/U/J 4 cycles, load 5, store 4, branch 3, measured FETCH to next FETCH.
REQ-032 A wait counter clears on every state entry and increments each cycle in FETCH or MEM while ready is low.
REQ-033 When the wait counter reaches WAIT_MAX with ready still low: fault is set, and the FSM moves to HALT.
REQ-034 If ready arrives in the same cycle the counter reaches WAIT_MAX, ready wins and no fault is raised.
REQ-035 HALT: all control outputs are 0, and the FSM remains in HALT until reset; fault holds its value.

Reset
REQ-036 Asserting rst_n low immediately forces state=FETCH, op_q=func_q=0, wait counter=0, fault=0, and all registered state to 0, including in the middle of any handshake.
REQ-037 The first fetch request is issued in the first cycle after rst_n deasserts; any abandoned memory request is not resumed.

Verification
REQ-038 ADD (op 000, func 000), ready tied high -> states 000,001,010,100; alu_op=000, flag=0, alu_s2=1 in EXEC; reg_wr=1, pc_en=1 in WB.
REQ-039 Load (op 010), dmem_ready delayed 3 cycles -> MEM held 4 cycles with dmem_req=1, mem_wr=0; then WB with wb_sel=01.
REQ-040 Branch (op 100) with branch_taken=1 -> EXEC pc_en=1, pc_sel=01, next state FETCH; with branch_taken=0 -> pc_sel=00.
REQ-041 imem_ready held low -> after WAIT_MAX=15 wait cycles, fault=1 and state=101; ready arriving exactly at the 15th cycle -> no fault.
REQ-042 rst_n pulsed low in MEM of a store -> state=000 immediately, dmem_req=0, no pc_en; the next fetch starts after release.
REQ-043 op 111 -> DECODE then HALT; subsequent imem_ready pulses are ignored; state stays 101.
